// File: rtl/model_config_mem.sv
// Training-model config store (params, fwd/bwd sparsity) with derived per-layer costs; 1-cycle registered read, no backpressure.
// Optional MODEL_CONFIG_SATURATE_EN clamps derived results to all-ones instead of truncating to the low DATA_W bits.
module model_config_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] config_data_i,
    input  logic [ADDR_W-1:0] config_addr_i,
    input  logic              config_valid_i,
    input  logic [ADDR_W-1:0] model_addr_i,
    input  logic              model_read_valid_i,
    output logic [DATA_W-1:0] model_data_o
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] RG_PARAMS = 3'd0;
    localparam logic [2:0] RG_FSP    = 3'd1;
    localparam logic [2:0] RG_BSP    = 3'd2;
    localparam logic [2:0] RG_IMEM   = 3'd3;
    localparam logic [2:0] RG_FCOMP  = 3'd4;
    localparam logic [2:0] RG_BCOMP  = 3'd5;

    logic [DATA_W-1:0] params_q [DEPTH];
    logic [DATA_W-1:0] params_d [DEPTH];
    logic [DATA_W-1:0] fsp_q    [DEPTH];
    logic [DATA_W-1:0] fsp_d    [DEPTH];
    logic [DATA_W-1:0] bsp_q    [DEPTH];
    logic [DATA_W-1:0] bsp_d    [DEPTH];
    logic [DATA_W-1:0] model_data_q;
    logic [DATA_W-1:0] model_data_d;

    logic [2:0]       wr_region;
    logic [IDX_W-1:0] wr_idx;
    logic [2:0]       rd_region;
    logic [IDX_W-1:0] rd_idx;

    assign wr_region = config_addr_i[10:8];
    assign wr_idx    = config_addr_i[IDX_W-1:0];
    assign rd_region = model_addr_i[10:8];
    assign rd_idx    = model_addr_i[IDX_W-1:0];

    always_comb begin
        params_d = params_q;
        fsp_d    = fsp_q;
        bsp_d    = bsp_q;
        if (config_valid_i) begin
            case (wr_region)
                RG_PARAMS: params_d[wr_idx] = config_data_i;
                RG_FSP:    fsp_d[wr_idx]    = config_data_i;
                RG_BSP:    bsp_d[wr_idx]    = config_data_i;
                default:   ;
            endcase
        end
    end

    logic [63:0]       b64, s64, a64, h64;
    logic [DATA_W-1:0] fl, bl, idx_ext, fsp_raw, bsp_raw;
    logic [6:0]        fkeep, bkeep;
    logic              fwd_on, bwd_on, is_xfmr;
    logic [63:0]       ibase, fbase, imem, fcomp, bcomp, derived_sel;
    logic [DATA_W-1:0] derived_fit;

    always_comb begin
        b64     = 64'(params_q[1]);
        fl      = params_q[2];
        bl      = params_q[3];
        s64     = 64'(params_q[4]);
        a64     = 64'(params_q[5]);
        h64     = 64'(params_q[6]);
        is_xfmr = (params_q[0] == DATA_W'(1));
        idx_ext = DATA_W'(rd_idx);
        fsp_raw = fsp_q[rd_idx];
        bsp_raw = bsp_q[rd_idx];
        // Sparsity above 100% is clamped, so the kept fraction never goes negative.
        fkeep   = (fsp_raw > DATA_W'(100)) ? 7'd0 : 7'(DATA_W'(100) - fsp_raw);
        bkeep   = (bsp_raw > DATA_W'(100)) ? 7'd0 : 7'(DATA_W'(100) - bsp_raw);
        fwd_on  = idx_ext < fl;
        bwd_on  = fwd_on && ((bl >= fl) || (idx_ext >= fl - bl));
        ibase   = b64 * s64 * h64;
        fbase   = b64 * s64 * h64 * h64 + b64 * a64 * s64 * s64;
        imem    = fwd_on ? (ibase * 64'(fkeep)) / 64'd100 : 64'd0;
        fcomp   = fwd_on ? (fbase * 64'(fkeep)) / 64'd100 : 64'd0;
        bcomp   = bwd_on ? ((fbase << 1) * 64'(bkeep)) / 64'd100 : 64'd0;
        derived_sel = 64'd0;
        if (is_xfmr) begin
            case (rd_region)
                RG_IMEM:  derived_sel = imem;
                RG_FCOMP: derived_sel = fcomp;
                RG_BCOMP: derived_sel = bcomp;
                default:  derived_sel = 64'd0;
            endcase
        end
`ifdef MODEL_CONFIG_SATURATE_EN
        derived_fit = (|derived_sel[63:DATA_W]) ? {DATA_W{1'b1}} : derived_sel[DATA_W-1:0];
`else
        derived_fit = derived_sel[DATA_W-1:0];
`endif
    end

    always_comb begin
        model_data_d = model_data_q;
        if (model_read_valid_i) begin
            case (rd_region)
                RG_PARAMS: model_data_d = params_q[rd_idx];
                RG_FSP:    model_data_d = fsp_q[rd_idx];
                RG_BSP:    model_data_d = bsp_q[rd_idx];
                RG_IMEM, RG_FCOMP, RG_BCOMP: model_data_d = derived_fit;
                default:   model_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                params_q[i] <= '0;
                fsp_q[i]    <= '0;
                bsp_q[i]    <= '0;
            end
            model_data_q <= '0;
        end else begin
            params_q     <= params_d;
            fsp_q        <= fsp_d;
            bsp_q        <= bsp_d;
            model_data_q <= model_data_d;
        end
    end

    assign model_data_o = model_data_q;

    logic unused_bits;
    assign unused_bits = ^{config_addr_i[ADDR_W-1:11], config_addr_i[7:IDX_W],
                           model_addr_i[ADDR_W-1:11], model_addr_i[7:IDX_W],
                           derived_sel[63:DATA_W]};

endmodule

// File: tb/tb_model_config_mem.sv
// Scoreboarded random + directed bench for model_config_mem against an arithmetic reference model.
module tb_model_config_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_dat;
    logic [31:0] cfg_addr;
    logic        cfg_vld;
    logic [31:0] rd_addr;
    logic        rd_vld;
    logic [31:0] dout;

    always #5 clk = ~clk;

    model_config_mem dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .config_data_i      (cfg_dat),
        .config_addr_i      (cfg_addr),
        .config_valid_i     (cfg_vld),
        .model_addr_i       (rd_addr),
        .model_read_valid_i (rd_vld),
        .model_data_o       (dout)
    );

    int unsigned mp [32];
    int unsigned fs [32];
    int unsigned bs [32];

    logic [31:0] exp_q [$];
    logic [31:0] last_exp = 32'd0;
    logic        rd_seen  = 1'b0;
    logic        rst_seen = 1'b0;
    int          n_chk    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          done     = 0;

    function automatic logic [31:0] mk_addr(input int r, input int i);
        logic [31:0] junk;
        junk = $urandom();
        return {junk[31:11], 3'(r), junk[7:5], 5'(i)};
    endfunction

    function automatic logic [31:0] fit(input longint unsigned v);
`ifdef MODEL_CONFIG_SATURATE_EN
        if (v > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_read(input int r, input int i);
        longint unsigned b, fl, bl, s, a, h, ib, fb, fk, bk, li;
        if (r == 0) return mp[i];
        if (r == 1) return fs[i];
        if (r == 2) return bs[i];
        if (r > 5 || mp[0] != 1) return 32'd0;
        b = mp[1]; fl = mp[2]; bl = mp[3]; s = mp[4]; a = mp[5]; h = mp[6];
        li = longint'(i);
        ib = b * s * h;
        fb = b * s * h * h + b * a * s * s;
        fk = 100 - ((fs[i] > 100) ? 100 : fs[i]);
        bk = 100 - ((bs[i] > 100) ? 100 : bs[i]);
        if (li >= fl) return 32'd0;
        if (r == 3) return fit(ib * fk / 100);
        if (r == 4) return fit(fb * fk / 100);
        if (bl < fl && li < fl - bl) return 32'd0;
        return fit(2 * fb * bk / 100);
    endfunction

    // One clock of stimulus; the expected read result is captured before the write lands.
    task automatic cycle(input bit do_rst, input bit wr, input int wr_r, input int wr_i,
                         input logic [31:0] wd, input bit rd, input int rd_r, input int rd_i,
                         input bit use_ovr, input logic [31:0] ovr);
        @(negedge clk);
        rst      = do_rst;
        cfg_vld  = wr;
        cfg_addr = mk_addr(wr_r, wr_i);
        cfg_dat  = wd;
        rd_vld   = rd;
        rd_addr  = mk_addr(rd_r, rd_i);
        if (do_rst) begin
            for (int k = 0; k < 32; k++) begin
                mp[k] = 0; fs[k] = 0; bs[k] = 0;
            end
        end else begin
            if (rd) exp_q.push_back(use_ovr ? ovr : ref_read(rd_r, rd_i));
            if (wr && wr_r == 0) mp[wr_i] = wd;
            if (wr && wr_r == 1) fs[wr_i] = wd;
            if (wr && wr_r == 2) bs[wr_i] = wd;
        end
    endtask

    task automatic wr(input int r, input int i, input logic [31:0] d);
        cycle(0, 1, r, i, d, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_chk(input int r, input int i, input logic [31:0] e);
        cycle(0, 0, 0, 0, 0, 1, r, i, 1, e);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        rd_seen  <= rd_vld && !rst;
        rst_seen <= rst;
        cyc      <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!done) begin
            if (rst_seen) begin
                last_exp = 32'd0;
            end else if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow cyc=%0d got=%h required=queued entry", cyc, dout);
                end else begin
                    last_exp = exp_q.pop_front();
                end
            end
            n_chk++;
            if (dout !== last_exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h required=%h",
                         rd_seen ? "read_data" : "hold_data", cyc, dout, last_exp);
            end
        end
    end

    initial begin
        rst = 1'b1; cfg_vld = 1'b0; rd_vld = 1'b0; cfg_dat = '0; cfg_addr = '0; rd_addr = '0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset wins over a concurrent write and read.
        cycle(1, 1, 0, 6, 32'hDEAD_BEEF, 1, 0, 6, 0, 0);
        rd_chk(0, 6, 0);
        rd_chk(1, 3, 0);
        rd_chk(5, 6, 0);

        wr(0, 1, 4);
        rd_chk(0, 1, 4);
        idle(); idle();

        wr(0, 0, 1); wr(0, 1, 4); wr(0, 2, 12); wr(0, 3, 6);
        wr(0, 4, 2); wr(0, 5, 12); wr(0, 6, 64);
        for (int k = 3; k <= 5; k++) wr(1, k, 15);
        for (int k = 6; k <= 8; k++) wr(1, k, 25);
        for (int k = 9; k <= 11; k++) wr(1, k, 80);
        for (int k = 6; k <= 8; k++) wr(2, k, 66);
        rd_chk(3, 0, 512);   rd_chk(3, 3, 435);   rd_chk(3, 6, 384);
        rd_chk(3, 9, 102);   rd_chk(3, 12, 0);
        rd_chk(4, 0, 32960); rd_chk(4, 3, 28016); rd_chk(4, 6, 24720);
        rd_chk(4, 9, 6592);  rd_chk(4, 12, 0);
        for (int k = 0; k <= 5; k++) rd_chk(5, k, 0);
        for (int k = 6; k <= 8; k++) rd_chk(5, k, 22412);
        for (int k = 9; k <= 11; k++) rd_chk(5, k, 65920);
        rd_chk(5, 12, 0);
        idle();

        wr(0, 0, 0);
        rd_chk(3, 0, 0); rd_chk(4, 3, 0); rd_chk(5, 6, 0);
        wr(0, 0, 1);
        wr(4, 0, 123);
        rd_chk(3, 0, 512);
        rd_chk(4, 0, 32960);
        wr(1, 0, 150);
        rd_chk(3, 0, 0);
        cycle(0, 1, 0, 1, 77, 1, 0, 1, 1, 4);
        rd_chk(0, 1, 77);
        rd_chk(6, 2, 0); rd_chk(7, 9, 0);

        for (int n = 0; n < 600; n++) begin
            int wr_r, wr_i, rd_r, rd_i;
            logic [31:0] d;
            wr_r = $urandom_range(0, 7);
            wr_i = (wr_r == 0) ? $urandom_range(0, 9) : $urandom_range(0, 31);
            rd_r = $urandom_range(0, 7);
            rd_i = $urandom_range(0, 31);
            if (wr_r == 0 && wr_i == 0)      d = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'd1;
            else if (wr_r == 0 && wr_i <= 3) d = $urandom_range(0, 40);
            else if (wr_r == 0 && wr_i <= 6) d = $urandom_range(0, 3000);
            else if (wr_r <= 2 && wr_r >= 1) d = $urandom_range(0, 127);
            else                             d = $urandom();
            cycle(n == 300, $urandom_range(0, 1), wr_r, wr_i, d,
                  $urandom_range(0, 3) != 0, rd_r, rd_i, 0, 0);
        end
        idle(); idle(); idle();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d entries required=0", exp_q.size());
        end
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
